// File: rtl/stream_sink.sv
// Purpose: packet sink that checks an incrementing byte stream and packet length, with a periodic ready pattern.
// Latency: pulses and counters update one cycle after the accepted beat; ready is registered from rdy_cnt.
// Backpressure: ready follows a fixed RDY_ON/RDY_PERIOD duty cycle and is independent of valid.
// Ports: clk, rst_n (async active-low); valid/last/data upstream beat; ready to upstream;
//        pkt_done/seq_err/len_err one-cycle pulses; pkt_count/err_count saturating counters; state FSM.
module stream_sink #(
  parameter int LEN        = 4,
  parameter int RDY_PERIOD = 20,
  parameter int RDY_ON     = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        last,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        pkt_done,
  output logic        seq_err,
  output logic        len_err,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_RESYNC = 2'd2
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
  localparam logic [7:0] RDY_LAST = 8'(RDY_PERIOD - 1);
  localparam logic [7:0] RDY_ON_W = 8'(RDY_ON);

  state_e      state_q,     state_d;
  logic [7:0]  rdy_cnt_q,   rdy_cnt_d;
  logic        ready_q,     ready_d;
  logic [7:0]  beat_idx_q,  beat_idx_d;
  logic [7:0]  exp_data_q,  exp_data_d;
  logic        pkt_err_q,   pkt_err_d;
  logic        pkt_done_q,  pkt_done_d;
  logic        seq_err_q,   seq_err_d;
  logic        len_err_q,   len_err_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] err_count_q, err_count_d;

  logic        accept;
  logic        mism;
  logic [16:0] pkt_sum;
  logic [16:0] err_sum;

  assign accept = valid & ready_q;
  assign mism   = (data != exp_data_q);

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    exp_data_d = exp_data_q;
    pkt_err_d  = pkt_err_q;
    pkt_done_d = 1'b0;
    seq_err_d  = 1'b0;
    len_err_d  = 1'b0;

    // Ready pattern: free-running counter, ready registered from its compare.
    rdy_cnt_d = (rdy_cnt_q == RDY_LAST) ? 8'd0 : rdy_cnt_q + 8'd1;
    ready_d   = (rdy_cnt_q < RDY_ON_W);

    if (accept) begin
      seq_err_d  = mism;
      // data+1 equals exp_data+1 on a match, so one expression covers
      // both normal increment and resynchronisation after a mismatch.
      exp_data_d = data + 8'd1;

      case (state_q)
        S_RESYNC: begin
          if (last) begin
            state_d    = S_IDLE;
            beat_idx_d = 8'd0;
            pkt_err_d  = 1'b0;
          end
        end
        default: begin
          if (last) begin
            state_d    = S_IDLE;
            beat_idx_d = 8'd0;
            pkt_err_d  = 1'b0;
            if (beat_idx_q == LAST_IDX) begin
              pkt_done_d = ~(pkt_err_q | mism);
            end else begin
              len_err_d = 1'b1;
            end
          end else if (beat_idx_q == LAST_IDX) begin
            // Too many beats (or last missing when LEN=1): drop the rest.
            len_err_d  = 1'b1;
            state_d    = S_RESYNC;
            pkt_err_d  = 1'b0;
          end else begin
            state_d    = S_RECV;
            beat_idx_d = beat_idx_q + 8'd1;
            pkt_err_d  = pkt_err_q | mism;
          end
        end
      endcase
    end

    // Saturating counters; err_count can step by 2 when both errors coincide.
    pkt_sum     = {1'b0, pkt_count_q} + 17'(pkt_done_d);
    err_sum     = {1'b0, err_count_q} + 17'(seq_err_d) + 17'(len_err_d);
    pkt_count_d = pkt_sum[16] ? 16'hFFFF : pkt_sum[15:0];
    err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_cnt_q   <= 8'd0;
      ready_q     <= 1'b0;
      beat_idx_q  <= 8'd0;
      exp_data_q  <= 8'd0;
      pkt_err_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      pkt_count_q <= 16'd0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      rdy_cnt_q   <= rdy_cnt_d;
      ready_q     <= ready_d;
      beat_idx_q  <= beat_idx_d;
      exp_data_q  <= exp_data_d;
      pkt_err_q   <= pkt_err_d;
      pkt_done_q  <= pkt_done_d;
      seq_err_q   <= seq_err_d;
      len_err_q   <= len_err_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign ready     = ready_q;
  assign pkt_done  = pkt_done_q;
  assign seq_err   = seq_err_q;
  assign len_err   = len_err_q;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stream_sink.sv
// Purpose: directed scoreboard bench for stream_sink (default parameters).
// Latency: expected pulse triple is checked 1 time unit after the accepting edge.
// Backpressure: driver holds each beat until ready is seen high.
module tb_stream_sink;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        last;
  logic [7:0]  data;
  logic        ready;
  logic        pkt_done;
  logic        seq_err;
  logic        len_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Expected {pkt_done, seq_err, len_err} for each accepted beat.
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  int         nxt;
  int         idx;

  stream_sink dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .last      (last),
    .data      (data),
    .ready     (ready),
    .pkt_done  (pkt_done),
    .seq_err   (seq_err),
    .len_err   (len_err),
    .pkt_count (pkt_count),
    .err_count (err_count),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pulses for a beat accepted at an edge are visible just after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({pkt_done, seq_err, len_err} !== mon_e) begin
        errors++;
        $display("FAIL pulses: got done/seq/len=%b required %b at %0t",
                 {pkt_done, seq_err, len_err}, mon_e, $time);
      end
    end else if ({pkt_done, seq_err, len_err} !== 3'b000) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got done/seq/len=%b required 000 at %0t",
               {pkt_done, seq_err, len_err}, $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] d, input logic l, input logic [2:0] e);
    int t;
    valid = 1'b1;
    data  = d;
    last  = l;
    t     = 0;
    while (ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready not seen for data %0d, required within 100 cycles", d);
      valid = 1'b0;
      last  = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(negedge clk);
      valid = 1'b0;
      last  = 1'b0;
    end
  endtask

  task automatic do_reset();
    valid = 1'b0;
    last  = 1'b0;
    data  = 8'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pulses_state", 32'({pkt_done, seq_err, len_err, state}), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_at_release", 32'(ready), 32'd0);
    @(negedge clk);
    chk("ready_one_after_release", 32'(ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    valid = 1'b0;
    last  = 1'b0;
    data  = 8'd0;
    #2;

    // Ready duty cycle with valid held high; packets of 4 in order.
    do_reset();
    nxt = 0;
    idx = 0;
    for (int k = 1; k <= 40; k++) begin
      valid = 1'b1;
      data  = 8'(nxt);
      last  = (idx == 3);
      chk("ready_pattern", 32'(ready), 32'(((k - 1) % 20) < 12));
      if (ready) begin
        exp_q.push_back({(idx == 3), 2'b00});
        nxt++;
        idx = (idx + 1) % 4;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    last  = 1'b0;
    @(negedge clk);
    chk("hold_valid_pkt_count", 32'(pkt_count), 32'd6);
    chk("hold_valid_err_count", 32'(err_count), 32'd0);
    chk("hold_valid_state", 32'(state), 32'd0);

    // Two clean packets.
    do_reset();
    send(8'd0, 1'b0, 3'b000);
    send(8'd1, 1'b0, 3'b000);
    send(8'd2, 1'b0, 3'b000);
    send(8'd3, 1'b1, 3'b100);
    send(8'd4, 1'b0, 3'b000);
    send(8'd5, 1'b0, 3'b000);
    send(8'd6, 1'b0, 3'b000);
    send(8'd7, 1'b1, 3'b100);
    chk("two_pkt_count", 32'(pkt_count), 32'd2);
    chk("two_err_count", 32'(err_count), 32'd0);

    // Short packet, then beat 3 starts a new packet.
    do_reset();
    send(8'd0, 1'b0, 3'b000);
    send(8'd1, 1'b0, 3'b000);
    send(8'd2, 1'b1, 3'b001);
    chk("short_state", 32'(state), 32'd0);
    chk("short_err_count", 32'(err_count), 32'd1);
    send(8'd3, 1'b0, 3'b000);
    chk("short_next_state", 32'(state), 32'd1);
    send(8'd4, 1'b0, 3'b000);
    send(8'd5, 1'b0, 3'b000);
    send(8'd6, 1'b1, 3'b100);
    chk("short_next_pkt_count", 32'(pkt_count), 32'd1);

    // Sequence error mid packet; resync makes beat 10 good, packet not done.
    do_reset();
    send(8'd0,  1'b0, 3'b000);
    send(8'd1,  1'b0, 3'b000);
    send(8'd9,  1'b0, 3'b010);
    send(8'd10, 1'b1, 3'b000);
    chk("seq_pkt_count", 32'(pkt_count), 32'd0);
    chk("seq_err_count", 32'(err_count), 32'd1);
    chk("seq_state", 32'(state), 32'd0);

    // Long packet: len_err on fourth beat, RESYNC until last.
    do_reset();
    send(8'd0, 1'b0, 3'b000);
    send(8'd1, 1'b0, 3'b000);
    send(8'd2, 1'b0, 3'b000);
    send(8'd3, 1'b0, 3'b001);
    chk("long_state_resync", 32'(state), 32'd2);
    send(8'd4, 1'b1, 3'b000);
    chk("long_state_idle", 32'(state), 32'd0);
    chk("long_pkt_count", 32'(pkt_count), 32'd0);
    chk("long_err_count", 32'(err_count), 32'd1);

    // Sequence and length error on the same beat: err_count steps by 2.
    do_reset();
    send(8'd0,  1'b0, 3'b000);
    send(8'd1,  1'b0, 3'b000);
    send(8'd2,  1'b0, 3'b000);
    send(8'd9,  1'b0, 3'b011);
    chk("both_err_count", 32'(err_count), 32'd2);
    chk("both_state", 32'(state), 32'd2);
    send(8'd10, 1'b1, 3'b000);
    chk("both_state_idle", 32'(state), 32'd0);

    // Reset mid packet, then a clean packet starting from 0.
    do_reset();
    send(8'd0, 1'b0, 3'b000);
    send(8'd1, 1'b0, 3'b000);
    chk("mid_state_recv", 32'(state), 32'd1);
    do_reset();
    send(8'd0, 1'b0, 3'b000);
    send(8'd1, 1'b0, 3'b000);
    send(8'd2, 1'b0, 3'b000);
    send(8'd3, 1'b1, 3'b100);
    chk("mid_pkt_count", 32'(pkt_count), 32'd1);
    chk("mid_err_count", 32'(err_count), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
